// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the core's fetch / load-store port. Accepts one
// read or write request at a time over a valid/ready handshake and returns a
// response after LATENCY wait states. Storage is a word-organised RAM.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         synchronous, active-low reset
//   req_valid   request present                  req_ready  responder can accept
//   req_we      1 = write, 0 = read              req_addr   byte address
//   req_wdata   write data                       req_be     write byte enables
//   resp_valid  response present                 resp_ready initiator accepts
//   resp_rdata  read data (0 for writes)         resp_err   access error
//
// Optional feature macro: MEM_ERR_EN
//   defined   : misaligned or out-of-range addresses skip the RAM and answer
//               with resp_err=1, resp_rdata=0
//   undefined : resp_err tied 0, low address bits ignored, index wraps
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [WIDTH-1:0]   req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    input  logic [WIDTH/8-1:0] req_be,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [WIDTH-1:0]   resp_rdata,
    output logic               resp_err
);

    localparam int unsigned NB    = WIDTH / 8;
    localparam int unsigned LSB   = $clog2(NB);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic             ready_q, ready_d;
    logic             rvalid_q, rvalid_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             accept_c;
    logic             cur_we_c;
    logic [WIDTH-1:0] cur_addr_c;
    logic [IDX_W-1:0] idx_c;
    logic             err_c;
    logic             enter_resp_c;

    // In IDLE the live request is decoded so a zero-latency read can sample
    // the RAM on its acceptance edge; afterwards the latched copy is used.
    assign accept_c   = req_valid && ready_q;
    assign cur_we_c   = (state_q == S_IDLE) ? req_we   : we_q;
    assign cur_addr_c = (state_q == S_IDLE) ? req_addr : addr_q;
    assign idx_c      = cur_addr_c[LSB +: IDX_W];

`ifdef MEM_ERR_EN
    // Misaligned byte offset or word index beyond the array.
    assign err_c = (cur_addr_c[LSB-1:0] != '0) ||
                   ((cur_addr_c >> LSB) >= WIDTH'(DEPTH));
`else
    logic unused_addr_bits;
    assign err_c            = 1'b0;
    assign unused_addr_bits = ^{cur_addr_c[WIDTH-1:LSB+IDX_W], cur_addr_c[LSB-1:0]};
`endif

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        ready_d      = ready_q;
        rvalid_d     = rvalid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        enter_resp_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (accept_c) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    ready_d = 1'b0;
                    if (LATENCY > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end else begin
                        enter_resp_c = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    enter_resp_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d  = S_IDLE;
                    rvalid_d = 1'b0;
                    ready_d  = 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                rvalid_d = 1'b0;
                ready_d  = 1'b1;
            end
        endcase

        // Read data is captured on the edge that enters RESP.
        if (enter_resp_c) begin
            state_d  = S_RESP;
            rvalid_d = 1'b1;
            err_d    = err_c;
            rdata_d  = (!cur_we_c && !err_c) ? mem_q[idx_c] : '0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Writes commit on the acceptance edge; RAM is never cleared by reset.
    always_ff @(posedge clk) begin
        if (rst && (state_q == S_IDLE) && accept_c && req_we && !err_c) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (req_be[b]) begin
                    mem_q[idx_c][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = rvalid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel_r;          // 0: LATENCY=2 instance, 1: LATENCY=0 instance
    logic        req_valid, req_we, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;

    logic        l2_ready, l2_valid, l2_err;
    logic [31:0] l2_rdata;
    logic        l0_ready, l0_valid, l0_err;
    logic [31:0] l0_rdata;

    logic        ready_c, valid_c, err_c;
    logic [31:0] rdata_c;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl [2][256];

    always #5 clk = ~clk;

    mem_responder #(.WIDTH(32), .DEPTH(256), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && !sel_r), .req_ready(l2_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(l2_valid), .resp_ready(resp_ready && !sel_r),
        .resp_rdata(l2_rdata), .resp_err(l2_err)
    );

    mem_responder #(.WIDTH(32), .DEPTH(256), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel_r), .req_ready(l0_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(l0_valid), .resp_ready(resp_ready && sel_r),
        .resp_rdata(l0_rdata), .resp_err(l0_err)
    );

    assign ready_c = sel_r ? l0_ready : l2_ready;
    assign valid_c = sel_r ? l0_valid : l2_valid;
    assign err_c   = sel_r ? l0_err   : l2_err;
    assign rdata_c = sel_r ? l0_rdata : l2_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_err(input logic [31:0] a);
`ifdef MEM_ERR_EN
        return (a % 4 != 0) || ((a / 4) >= 256);
`else
        return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    // Hold reset three cycles, optionally with a write request pending.
    task automatic do_reset(input bit with_req);
        sel_r = 1'b0; resp_ready = 1'b0;
        rst = 1'b0; req_valid = with_req;
        req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_valid_l2", 32'(l2_valid), 32'd0);
            chk("rst_valid_l0", 32'(l0_valid), 32'd0);
            chk("rst_ready_l2", 32'(l2_ready), 32'd0);
            chk("rst_rdata_l2", l2_rdata, 32'd0);
            chk("rst_err_l2",   32'(l2_err), 32'd0);
        end
        rst = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready_l2", 32'(l2_ready), 32'd1);
        chk("post_rst_ready_l0", 32'(l0_ready), 32'd1);
    endtask

    // One full transaction against the selected instance, checked against mdl.
    task automatic txn(input bit sel, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input int stall, input bit early, output logic [31:0] rd);
        int          lat;
        int          k;
        int          idx;
        bit          exp_err;
        logic [31:0] exp_rd;
        logic [31:0] held;

        lat     = sel ? 0 : 2;
        idx     = int'((addr / 4) % 256);
        exp_err = m_err(addr);
        exp_rd  = 32'd0;
        if (!exp_err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mdl[sel][idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                exp_rd = mdl[sel][idx];
            end
        end

        sel_r = sel;
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
        k = 0;
        while (!ready_c && k < 20) begin @(posedge clk); #1; k++; end
        chk("ready_before_accept", 32'(ready_c), 32'd1);
        @(posedge clk); #1;
        req_valid  = 1'b0;
        resp_ready = early;

        k = 0;
        while (!valid_c && k < 20) begin @(posedge clk); #1; k++; end
        chk("latency", 32'(k), 32'(lat));
        chk("rdata", rdata_c, exp_rd);
        chk("err", 32'(err_c), 32'(exp_err));
        rd   = rdata_c;
        held = rdata_c;

        if (!early) begin
            // A competing write to the same word must be ignored while busy.
            for (int s = 0; s < stall; s++) begin
                req_valid = 1'b1; req_we = 1'b1; req_addr = addr;
                req_wdata = $urandom; req_be = 4'hF;
                @(posedge clk); #1;
                chk("stall_valid", 32'(valid_c), 32'd1);
                chk("stall_rdata", rdata_c, held);
                chk("stall_ready", 32'(ready_c), 32'd0);
            end
            req_valid = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("post_hs_valid", 32'(valid_c), 32'd0);
        chk("post_hs_ready", 32'(ready_c), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;

        do_reset(1'b0);

        // LATENCY=2 write then read-back.
        txn(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, rd);
        txn(0, 0, 32'h10, 32'h0, 4'hF, 0, 0, rd);
        chk("wr_rd_10", rd, 32'hDEAD_BEEF);

        // Byte-lane merge and zero-enable write.
        txn(0, 1, 32'h20, 32'h1122_3344, 4'hF, 0, 0, rd);
        txn(0, 1, 32'h20, 32'hAABB_CCDD, 4'h5, 0, 0, rd);
        txn(0, 0, 32'h20, 32'h0, 4'h0, 0, 0, rd);
        chk("be_merge", rd, 32'h11BB_33DD);
        txn(0, 1, 32'h20, 32'hFFFF_FFFF, 4'h0, 0, 0, rd);
        txn(0, 0, 32'h20, 32'h0, 4'h0, 0, 1, rd);
        chk("be_zero", rd, 32'h11BB_33DD);

        // Backpressure with a competing request held during the stall.
        txn(0, 0, 32'h10, 32'h0, 4'hF, 5, 0, rd);
        txn(0, 0, 32'h10, 32'h0, 4'hF, 0, 0, rd);
        chk("ghost_ignored", rd, 32'hDEAD_BEEF);

        // Reset with a pending write must not disturb RAM.
        txn(0, 1, 32'h30, 32'h1234_5678, 4'hF, 0, 0, rd);
        do_reset(1'b1);
        txn(0, 0, 32'h30, 32'h0, 4'hF, 0, 0, rd);
        chk("rst_no_write", rd, 32'h1234_5678);

        // LATENCY=0 back-to-back traffic.
        txn(1, 1, 32'h0, 32'hA5A5_0001, 4'hF, 0, 0, rd);
        txn(1, 1, 32'h4, 32'h5A5A_0002, 4'hF, 0, 0, rd);
        txn(1, 0, 32'h0, 32'h0, 4'hF, 0, 0, rd);
        chk("l0_rd0", rd, 32'hA5A5_0001);
        txn(1, 0, 32'h4, 32'h0, 4'hF, 0, 0, rd);
        chk("l0_rd4", rd, 32'h5A5A_0002);

        // Out-of-range and misaligned addresses.
        txn(0, 1, 32'h0, 32'h0BAD_F00D, 4'hF, 0, 0, rd);
        txn(0, 0, 32'h400, 32'h0, 4'hF, 0, 0, rd);
`ifndef MEM_ERR_EN
        chk("wrap_400", rd, 32'h0BAD_F00D);
`endif
        txn(0, 0, 32'h402, 32'h0, 4'hF, 0, 0, rd);
        txn(0, 1, 32'h12, 32'h7777_8888, 4'hF, 0, 0, rd);
        txn(0, 0, 32'h10, 32'h0, 4'hF, 0, 0, rd);

        // Fill a small window of words, then random traffic over it.
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 16; w++)
                txn(s[0], 1, 32'(w * 4), $urandom, 4'hF, 0, 0, rd);
        for (int n = 0; n < 80; n++) begin
            a = 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) a = a + 32'h400;
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                4'($urandom_range(0, 15)), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0), rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
